// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter and write sequencer for one shared enabled register, with bounded lock bursts.
// Optional per-requester committed-write counters are enabled by defining ARB_STATS_EN.
module reg_share_arbiter #(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             lock0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic             lock1,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             en,
  output logic [WIDTH-1:0] q,
  output logic             busy
`ifdef ARB_STATS_EN
  ,
  output logic [7:0]       wcnt0,
  output logic [7:0]       wcnt1
`endif
);

  localparam int HC_W = $clog2(HOLD_MAX) + 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state, state_nx;
  logic            last_winner, last_winner_nx;
  logic [HC_W-1:0] hold_cnt, hold_cnt_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nx;
      last_winner <= last_winner_nx;
      hold_cnt    <= hold_cnt_nx;
    end
  end

  // Hand-over goes straight to the other owner; hold_cnt saturates by construction.
  always_comb begin
    state_nx       = state;
    last_winner_nx = last_winner;
    hold_cnt_nx    = hold_cnt;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last_winner)) begin
          state_nx       = OWN0;
          last_winner_nx = 1'b0;
          hold_cnt_nx    = '0;
        end else if (req1) begin
          state_nx       = OWN1;
          last_winner_nx = 1'b1;
          hold_cnt_nx    = '0;
        end
      end
      OWN0: begin
        if (req0 && lock0 && (hold_cnt < HOLD_LAST)) begin
          hold_cnt_nx = hold_cnt + HC_W'(1);
        end else if (req1) begin
          state_nx       = OWN1;
          last_winner_nx = 1'b1;
          hold_cnt_nx    = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      OWN1: begin
        if (req1 && lock1 && (hold_cnt < HOLD_LAST)) begin
          hold_cnt_nx = hold_cnt + HC_W'(1);
        end else if (req0) begin
          state_nx       = OWN0;
          last_winner_nx = 1'b0;
          hold_cnt_nx    = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);
  assign en   = (gnt0 & req0) | (gnt1 & req1);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= gnt0 ? d0 : d1;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt0 <= '0;
      wcnt1 <= '0;
    end else begin
      if (gnt0 && req0 && (wcnt0 != 8'hFF)) wcnt0 <= wcnt0 + 8'd1;
      if (gnt1 && req1 && (wcnt1 != 8'hFF)) wcnt1 <= wcnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: expected q values are queued per driven cycle and popped after the edge.
module tb_reg_share_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, lock0, req1, lock1;
  logic [3:0] d0, d1;
  logic       gnt0, gnt1, en, busy;
  logic [3:0] q;
`ifdef ARB_STATS_EN
  logic [7:0] wcnt0, wcnt1;
`endif

  int checks   = 0;
  int failures = 0;
  logic [3:0] sb[$];

  reg_share_arbiter #(.WIDTH(4), .HOLD_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .d0(d0),
    .req1(req1), .lock1(lock1), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1), .en(en), .q(q), .busy(busy)
`ifdef ARB_STATS_EN
    , .wcnt0(wcnt0), .wcnt1(wcnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check grant outputs at negedge, check q after the edge.
  task automatic cyc(input string tag,
                     input logic r0, input logic l0, input logic [3:0] a0,
                     input logic r1, input logic l1, input logic [3:0] a1,
                     input logic eg0, input logic eg1, input logic ee,
                     input logic [3:0] eq);
    logic [3:0] exp_q;
    req0 = r0; lock0 = l0; d0 = a0;
    req1 = r1; lock1 = l1; d1 = a1;
    sb.push_back(eq);
    @(negedge clk);
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(eg0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(eg1));
    chk({tag, ".en"},   32'(en),   32'(ee));
    chk({tag, ".busy"}, 32'(busy), 32'(eg0 | eg1));
    @(posedge clk); #1;
    exp_q = sb.pop_front();
    chk({tag, ".q"}, 32'(q), 32'(exp_q));
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; lock0 = 0; d0 = 0; req1 = 0; lock1 = 0; d1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.q", 32'(q), 32'h0);
    chk("rst.gnt0", 32'(gnt0), 32'h0);
    chk("rst.gnt1", 32'(gnt1), 32'h0);
    chk("rst.en", 32'(en), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    reset = 1'b0;

    // single write from requester 0
    cyc("t1a", 1,0,4'hA, 0,0,4'h0, 0,0,0, 4'h0);
    cyc("t1b", 1,0,4'hA, 0,0,4'h0, 1,0,1, 4'hA);
    cyc("t1c", 0,0,4'h0, 0,0,4'h0, 0,0,0, 4'hA);

    reset = 1'b1; #2; reset = 1'b0;
    chk("pulse.q", 32'(q), 32'h0);

    // tie from IDLE, alternating grants with no bubble
    cyc("t2a", 1,0,4'h1, 1,0,4'h2, 0,0,0, 4'h0);
    cyc("t2b", 1,0,4'h3, 1,0,4'h4, 1,0,1, 4'h3);
    cyc("t2c", 1,0,4'h5, 1,0,4'h6, 0,1,1, 4'h6);
    cyc("t2d", 1,0,4'h7, 1,0,4'h8, 1,0,1, 4'h7);
    cyc("t2e", 1,0,4'h9, 1,0,4'hB, 0,1,1, 4'hB);
    cyc("t2f", 0,0,4'h0, 0,0,4'h0, 1,0,0, 4'hB);
    cyc("t2g", 0,0,4'h0, 0,0,4'h0, 0,0,0, 4'hB);

    // locked burst bounded by HOLD_MAX=3 while requester 1 waits
    cyc("t3a", 1,1,4'h1, 0,0,4'hE, 0,0,0, 4'hB);
    cyc("t3b", 1,1,4'h2, 1,0,4'hE, 1,0,1, 4'h2);
    cyc("t3c", 1,1,4'h3, 1,0,4'hE, 1,0,1, 4'h3);
    cyc("t3d", 1,1,4'h4, 1,0,4'hE, 1,0,1, 4'h4);
    cyc("t3e", 1,1,4'h5, 1,0,4'hE, 0,1,1, 4'hE);
    cyc("t3f", 0,0,4'h0, 0,0,4'h0, 1,0,0, 4'hE);
    cyc("t3g", 0,0,4'h0, 0,0,4'h0, 0,0,0, 4'hE);

    // owner drops request with lock still high: leaves to IDLE, no write
    cyc("t4a", 0,0,4'h0, 1,0,4'h6, 0,0,0, 4'hE);
    cyc("t4b", 0,0,4'h0, 1,1,4'h7, 0,1,1, 4'h7);
    cyc("t4c", 0,0,4'h0, 0,1,4'hF, 0,1,0, 4'h7);
    cyc("t4d", 0,0,4'h0, 0,0,4'h0, 0,0,0, 4'h7);

    // async reset mid-burst, then tie goes back to requester 0
    cyc("t5a", 1,1,4'h5, 0,0,4'h0, 0,0,0, 4'h7);
    cyc("t5b", 1,1,4'h5, 0,0,4'h0, 1,0,1, 4'h5);
    #2 reset = 1'b1;
    #1;
    chk("t5rst.q", 32'(q), 32'h0);
    chk("t5rst.gnt0", 32'(gnt0), 32'h0);
    chk("t5rst.busy", 32'(busy), 32'h0);
    req0 = 0; lock0 = 0; d0 = 0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    cyc("t5c", 1,0,4'hC, 1,0,4'hD, 0,0,0, 4'h0);
    cyc("t5d", 0,0,4'h0, 0,0,4'h0, 1,0,0, 4'h0);

`ifdef ARB_STATS_EN
    begin
      int writes = 0;
      reset = 1'b1; #2; reset = 1'b0;
      req1 = 1; lock1 = 1; d1 = 4'h3;
      for (int i = 0; i < 1000 && writes < 300; i++) begin
        @(negedge clk);
        if (en) writes++;
      end
      chk("stats.writes", 32'(writes), 32'd300);
      @(posedge clk); #1;
      req1 = 0; lock1 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("stats.wcnt1", 32'(wcnt1), 32'd255);
      chk("stats.wcnt0", 32'(wcnt0), 32'd0);
    end
`endif

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
